// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares DataMemory between CPU (port 0) and DMA (port 1), screening bad accesses.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [2:0]  m0_funct3,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [2:0]  m1_funct3,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      r_state;
  logic        r_we, r_port, r_err;
  logic [31:0] r_addr, r_wd, r_rdata;
  logic [2:0]  r_f3;
  logic        w_open, w_gnt, w_hs, w_we, w_err, w_bad_f3, w_misal, w_resp;
  logic [31:0] w_addr, w_wd;
  logic [2:0]  w_f3;
`ifdef DMEM_ARB_RR_EN
  logic        r_last;
  assign w_gnt = (m0_req_valid & m1_req_valid) ? ~r_last : m1_req_valid;
`else
  assign w_gnt = ~m0_req_valid & m1_req_valid;
`endif
  // acceptance overlaps RESP, giving one access per two cycles
  assign w_open       = ~rst & (r_state != ACCESS);
  assign m0_req_ready = w_open & m0_req_valid & ~w_gnt;
  assign m1_req_ready = w_open & m1_req_valid & w_gnt;
  assign w_hs         = m0_req_ready | m1_req_ready;
  assign w_we         = w_gnt ? m1_we : m0_we;
  assign w_addr       = w_gnt ? m1_addr : m0_addr;
  assign w_wd         = w_gnt ? m1_wd : m0_wd;
  assign w_f3         = w_gnt ? m1_funct3 : m0_funct3;
  assign w_bad_f3     = w_we ? (w_f3 > 3'd2) : (w_f3 == 3'b011 || w_f3[2:1] == 2'b11);
  assign w_misal      = (w_f3[1:0] == 2'b01 && w_addr[0]) || (w_f3 == 3'b010 && w_addr[1:0] != 2'b00);
  assign w_err        = w_bad_f3 | w_misal | ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_f3    <= '0;
      r_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= (r_state == ACCESS) ? RESP : (w_hs ? ACCESS : IDLE);
      if (w_hs) begin
        r_we   <= w_we;
        r_addr <= w_addr;
        r_wd   <= w_wd;
        r_f3   <= w_f3;
        r_port <= w_gnt;
        r_err  <= w_err;
`ifdef DMEM_ARB_RR_EN
        r_last <= w_gnt;
`endif
      end
      if (r_state == ACCESS)
        r_rdata <= (r_we | r_err) ? '0 : mem_rdata;
    end
  end
  // reset clears r_state asynchronously, so mem_we drops without waiting for an edge
  assign mem_we       = (r_state == ACCESS) & r_we & ~r_err;
  assign mem_addr     = r_addr;
  assign mem_wd       = r_wd;
  assign mem_funct3   = r_f3;
  assign w_resp       = (r_state == RESP);
  assign m0_rsp_valid = w_resp & ~r_port;
  assign m1_rsp_valid = w_resp & r_port;
  assign m0_rsp_rdata = m0_rsp_valid ? r_rdata : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? r_rdata : '0;
  assign m0_rsp_err   = m0_rsp_valid & r_err;
  assign m1_rsp_err   = m1_rsp_valid & r_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter against a transaction-level model
// of arbitration, access screening and response timing, plus literal expectations.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        v [2];
  logic        we [2];
  logic [31:0] a [2];
  logic [31:0] wd [2];
  logic [2:0]  f3 [2];
  logic [1:0]  rdy, rv, re;
  logic [31:0] rd [2];
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int          errors = 0, checks = 0, we_cnt = 0;
  dmem_arbiter #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(v[0]), .m0_req_ready(rdy[0]), .m0_we(we[0]), .m0_addr(a[0]), .m0_wd(wd[0]),
    .m0_funct3(f3[0]), .m0_rsp_valid(rv[0]), .m0_rsp_rdata(rd[0]), .m0_rsp_err(re[0]),
    .m1_req_valid(v[1]), .m1_req_ready(rdy[1]), .m1_we(we[1]), .m1_addr(a[1]), .m1_wd(wd[1]),
    .m1_funct3(f3[1]), .m1_rsp_valid(rv[1]), .m1_rsp_rdata(rd[1]), .m1_rsp_err(re[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
    .mem_rdata(mem_rdata)
  );
  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] o, logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * o));
    h = 16'(w >> (16 * o[1]));
    case (f)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return w;
    endcase
  endfunction
  function automatic logic [31:0] st_merge(logic [31:0] w, logic [31:0] d, logic [1:0] o, logic [2:0] f);
    logic [31:0] m, s;
    m = (f[1:0] == 2'd0) ? (32'hFF << (8 * o)) : (f[1:0] == 2'd1) ? (32'hFFFF << (16 * o[1])) : 32'hFFFF_FFFF;
    s = (f[1:0] == 2'd0) ? (d << (8 * o)) : (f[1:0] == 2'd1) ? (d << (16 * o[1])) : d;
    return (w & ~m) | (s & m);
  endfunction
  function automatic bit bad(logic w, logic [31:0] ad, logic [2:0] f);
    bit legal;
    int sz;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f[1:0];
    return !legal || (ad / 4 >= 64) || (ad % sz != 0);
  endfunction
  assign mem_rdata = ld_ext(mem[mem_addr[7:2]], mem_addr[1:0], mem_funct3);
  always @(posedge clk) if (mem_we) begin
    mem[mem_addr[7:2]] <= st_merge(mem[mem_addr[7:2]], mem_wd, mem_addr[1:0], mem_funct3);
    we_cnt <= we_cnt + 1;
  end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  typedef struct packed {
    logic v, p, we;
    logic [31:0] a, d;
    logic [2:0] f;
    logic e;
  } acc_t;
  acc_t  s1 = '0, s2 = '0;
  bit    last = 1'b1, chk_en = 1'b0;
  bit    glog [$];
  time   tlog [$];
  // model: s1 is the access in flight this cycle, s2 the one being answered
  always @(negedge clk) begin : model
    logic        g;
    logic [1:0]  er;
    logic [31:0] x;
    if (rst || !chk_en) begin
      s1 = '0;
      s2 = '0;
      if (rst) last = 1'b1;
    end else begin
      g = (v[0] && v[1]) ? (RR ? !last : 1'b0) : v[1];
      er[0] = !s1.v && v[0] && !g;
      er[1] = !s1.v && v[1] && g;
      chk("ready0", rdy[0], er[0]);
      chk("ready1", rdy[1], er[1]);
      chk("mem_we", mem_we, s1.v && s1.we && !s1.e);
      if (s1.v) begin
        chk("mem_addr", mem_addr, s1.a);
        chk("mem_wd", mem_wd, s1.d);
        chk("mem_funct3", mem_funct3, s1.f);
      end
      for (int p = 0; p < 2; p++) begin
        chk("rsp_valid", rv[p], s2.v && s2.p == p);
        if (s2.v && s2.p == p) begin
          x = (s2.we || s2.e) ? 32'd0 : ld_ext(ref_mem[s2.a[7:2]], s2.a[1:0], s2.f);
          chk("rsp_rdata", rd[p], x);
          chk("rsp_err", re[p], s2.e);
        end
      end
      if (s1.v && s1.we && !s1.e)
        ref_mem[s1.a[7:2]] = st_merge(ref_mem[s1.a[7:2]], s1.d, s1.a[1:0], s1.f);
      s2 = s1;
      s1 = '0;
      if (er != 2'b00) begin
        s1.v  = 1'b1;
        s1.p  = er[1];
        s1.we = we[s1.p];
        s1.a  = a[s1.p];
        s1.d  = wd[s1.p];
        s1.f  = f3[s1.p];
        s1.e  = bad(s1.we, s1.a, s1.f);
        last  = er[1];
        glog.push_back(er[1]);
        tlog.push_back($time);
      end
    end
  end
  task automatic go(int p, logic w, logic [31:0] ad, logic [31:0] d, logic [2:0] f);
    int n = 0;
    v[p] = 1'b1; we[p] = w; a[p] = ad; wd[p] = d; f3[p] = f;
    do begin @(negedge clk); n++; end while (!rdy[p] && n < 60);
    if (!rdy[p]) begin
      checks++;
      errors++;
      $display("FAIL go_timeout port %0d: ready still 0 after 60 cycles, expected 1", p);
    end
    @(posedge clk); #1;
    v[p] = 1'b0;
  endtask
  task automatic rsp_chk(int p, string n, logic [31:0] xd, logic xe);
    @(negedge clk);
    @(negedge clk);
    chk({n, "_valid"}, rv[p], 1);
    chk({n, "_rdata"}, rd[p], xd);
    chk({n, "_err"}, re[p], xe);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int base;
    for (int i = 0; i < 64; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    for (int p = 0; p < 2; p++) begin v[p] = 0; we[p] = 0; a[p] = 0; wd[p] = 0; f3[p] = 0; end
    v[0] = 1'b1;
    a[0] = 32'h44;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_rsp_valid", rv, 0);
    chk("rst_rsp_rdata0", rd[0], 0);
    v[0] = 1'b0;
    a[0] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    base = we_cnt;
    go(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2); rsp_chk(0, "sw10", 32'h0, 1'b0);
    chk("sw_we_once", we_cnt, base + 1);
    go(0, 1'b0, 32'h10, 32'h0, 3'd2); rsp_chk(0, "lw10", 32'hDEADBEEF, 1'b0);
    go(0, 1'b1, 32'h0, 32'h000080F0, 3'd2); rsp_chk(0, "sw0", 32'h0, 1'b0);
    go(0, 1'b0, 32'h0, 32'h0, 3'd0); rsp_chk(0, "lb", 32'hFFFFFFF0, 1'b0);
    go(0, 1'b0, 32'h0, 32'h0, 3'd4); rsp_chk(0, "lbu", 32'h000000F0, 1'b0);
    go(0, 1'b0, 32'h0, 32'h0, 3'd1); rsp_chk(0, "lh", 32'hFFFF80F0, 1'b0);
    go(0, 1'b0, 32'h0, 32'h0, 3'd5); rsp_chk(0, "lhu", 32'h000080F0, 1'b0);
    base = we_cnt;
    go(0, 1'b0, 32'h102, 32'h0, 3'd2); rsp_chk(0, "err_lw102", 32'h0, 1'b1);
    go(0, 1'b1, 32'h1, 32'h1234, 3'd1); rsp_chk(0, "err_sh1", 32'h0, 1'b1);
    go(1, 1'b1, 32'h100, 32'h55AA55AA, 3'd2); rsp_chk(1, "err_sw100", 32'h0, 1'b1);
    go(1, 1'b0, 32'h0, 32'h0, 3'd3); rsp_chk(1, "err_ld011", 32'h0, 1'b1);
    chk("err_no_we", we_cnt, base);
    chk("err_word0", mem[0], 32'h000080F0);
    chk("err_word4", mem[4], 32'hDEADBEEF);
    glog.delete();
    tlog.delete();
    fork
      for (int i = 0; i < 6; i++) go(0, 1'b0, 32'(4 * i), 32'h0, 3'd2);
      for (int i = 0; i < 3; i++) go(1, 1'b0, 32'(16 + 4 * i), 32'h0, 3'd2);
    join
    repeat (3) @(posedge clk); #1;
    chk("tie_grants", glog.size(), 9);
    if (glog.size() >= 6)
      for (int i = 0; i < 6; i++) chk("tie_grant_port", glog[i], RR ? (i % 2) : 0);
    glog.delete();
    tlog.delete();
    go(1, 1'b0, 32'h10, 32'h0, 3'd2);
    go(1, 1'b0, 32'h0, 32'h0, 3'd2);
    go(1, 1'b0, 32'h4, 32'h0, 3'd2);
    go(1, 1'b0, 32'h10, 32'h0, 3'd2);
    repeat (3) @(posedge clk); #1;
    chk("stream_count", tlog.size(), 4);
    if (tlog.size() == 4)
      for (int i = 1; i < 4; i++) chk("stream_gap", 32'(tlog[i] - tlog[i-1]), 20);
    chk_en = 1'b0;
    base = we_cnt;
    go(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'd2);
    chk("pre_rst_mem_we", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_we", mem_we, 0);
    chk("rst_mid_ready", rdy, 0);
    chk("rst_mid_rsp_valid", rv, 0);
    chk("rst_mid_rsp_err", re, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wd", mem_wd, 0);
    chk("rst_mid_mem_funct3", mem_funct3, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_word20", mem[8], 0);
    chk("rst_no_we", we_cnt, base);
    @(negedge clk);
    chk("post_rst_rsp_valid", rv, 0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    go(0, 1'b0, 32'h20, 32'h0, 3'd2); rsp_chk(0, "lw20", 32'h0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
